// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receiver: state encoding and default bit timing.
`timescale 1ns/1ps
package uart_rx_pkg;

    localparam int unsigned CLKS_PER_BIT_DEFAULT = 434;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
`timescale 1ns/1ps
module sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a 16-bit down counter, level-style
// rx_done and a BREAK state so a stuck-low line reports a single framing error.
`timescale 1ns/1ps
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       reset,
    input  logic       clock,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       rx_busy
);

    localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);

    logic        rx_s;
    state_t      state;
    logic [15:0] cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg;
    logic [1:0]  settle;
    logic        armed;

    sync2 #(.RESET_VAL(1'b1)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    // The synchronizer resets high, so rx_s only reflects the real line once
    // settle is full; a start is accepted only after a genuine high was seen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[0], 1'b1};
            armed  <= armed | (settle[1] & rx_s);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            rx_busy   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s && armed) begin
                        cnt     <= HALF_BIT;
                        state   <= START;
                        rx_busy <= 1'b1;
                    end
                end
                START: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        rx_done <= 1'b0;
                        cnt     <= FULL_BIT;
                        bit_idx <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        shreg[bit_idx] <= rx_s;
                        cnt            <= FULL_BIT;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 16'd1;
                    end else if (rx_s) begin
                        rx_data <= shreg;
                        rx_done <= 1'b1;
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state   <= IDLE;
                        rx_busy <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 16 and 17 (skewed) clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx16 = 1'b1;
    logic       rx17 = 1'b1;
    logic [7:0] data16, data17;
    logic       done16, done17, ferr16, ferr17, busy16, busy17;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .reset(rst_n), .clock(clk), .rx(rx16),
        .rx_data(data16), .rx_done(done16), .frame_err(ferr16), .rx_busy(busy16)
    );

    uart_rx #(.CLKS_PER_BIT(17)) dut17 (
        .reset(rst_n), .clock(clk), .rx(rx17),
        .rx_data(data17), .rx_done(done17), .frame_err(ferr17), .rx_busy(busy17)
    );

    // Observers: rising rx_done captures a byte; frame_err pulses are counted
    // both as pulses and as high cycles so a stretched pulse shows up.
    logic [7:0] got16[$], got17[$], line_q[$];
    int rise16 = 0, rise17 = 0, fecnt16 = 0, fecnt17 = 0, fecyc16 = 0, fecyc17 = 0;
    int datachg16 = 0, busycyc16 = 0;
    logic prev16 = 0, prev17 = 0, pfe16 = 0, pfe17 = 0;
    logic [7:0] last16 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (done16 && !prev16) begin
                rise16++;
                got16.push_back(data16);
                line_q.push_back(data16 == 8'h0A ? 8'h00 : data16);
            end else if (data16 != last16) begin
                datachg16++;
            end
            if (done17 && !prev17) begin
                rise17++;
                got17.push_back(data17);
            end
            if (ferr16) begin fecyc16++; if (!pfe16) fecnt16++; end
            if (ferr17) begin fecyc17++; if (!pfe17) fecnt17++; end
            if (busy16) busycyc16++;
        end
        prev16 = done16; prev17 = done17; pfe16 = ferr16; pfe17 = ferr17;
        last16 = data16;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drive16(input logic v, input int n);
        rx16 = v;
        wait_cyc(n);
    endtask

    task automatic send16(input logic [7:0] b, input int stop_low);
        drive16(1'b0, 16);
        for (int i = 0; i < 8; i++) drive16(b[i], 16);
        if (stop_low > 0) drive16(1'b0, stop_low);
        drive16(1'b1, 16);
    endtask

    task automatic send17(input logic [7:0] b, input real bit_ns);
        rx17 = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin rx17 = b[i]; #(bit_ns); end
        rx17 = 1'b1;
        #(bit_ns * 2.0);
    endtask

    typedef struct {
        logic [7:0] data;
        int         stop_low;
        logic [7:0] exp_data;
        int         exp_rises;
        int         exp_fe;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n, r0, f0, b0, base, nbad;
        logic [7:0] d0, b;
        logic dn0;
        logic [7:0] exp_q[$];
        logic [7:0] s17[4];
        real sk17[4];

        tbl[0] = '{8'h00, 0,  8'h00, 1, 0};
        tbl[1] = '{8'hFF, 0,  8'hFF, 1, 0};
        tbl[2] = '{8'hA5, 0,  8'hA5, 1, 0};
        tbl[3] = '{8'h55, 40, 8'hA5, 0, 1};
        tbl[4] = '{8'h7E, 0,  8'h7E, 1, 0};
        tbl[5] = '{8'h81, 0,  8'h81, 1, 0};

        repeat (4) @(posedge clk);
        #1;
        check("rst_data", data16, 8'h00);
        check("rst_done", done16, 1'b0);
        check("rst_ferr", ferr16, 1'b0);
        check("rst_busy", busy16, 1'b0);
        rst_n = 1'b1;
        wait_cyc(20);

        // First byte: latency from the falling start edge to rx_done rising.
        n = 0;
        fork
            send16(8'h41, 0);
            begin
                do begin @(posedge clk); #1; n++; end while (!done16 && n < 400);
            end
        join
        check_rng("latency_41", n, 153, 155);
        check("data_41", data16, 8'h41);
        check("rises_41", rise16, 1);
        check("ferr_41", fecnt16, 0);

        for (int i = 0; i < 6; i++) begin
            r0 = rise16; f0 = fecnt16;
            send16(tbl[i].data, tbl[i].stop_low);
            wait_cyc(10);
            check($sformatf("tbl%0d_data", i), data16, tbl[i].exp_data);
            check($sformatf("tbl%0d_rises", i), rise16 - r0, tbl[i].exp_rises);
            check($sformatf("tbl%0d_ferr", i), fecnt16 - f0, tbl[i].exp_fe);
        end

        // Back-to-back frames with no idle gap, consumed by a line stage.
        r0 = rise16;
        line_q.delete();
        send16(8'h48, 0);
        send16(8'h0A, 0);
        wait_cyc(10);
        check("b2b_rises", rise16 - r0, 2);
        check("b2b_first", got16[got16.size()-2], 8'h48);
        check("b2b_second", got16[got16.size()-1], 8'h0A);
        check("line_len", line_q.size(), 2);
        if (line_q.size() == 2) begin
            check("line_h", line_q[0], 8'h48);
            check("line_term", line_q[1], 8'h00);
        end

        // Short low glitch on an idle line.
        r0 = rise16; f0 = fecnt16; b0 = busycyc16; d0 = data16; dn0 = done16;
        drive16(1'b0, 5);
        drive16(1'b1, 30);
        check("glitch_busy_seen", busycyc16 > b0, 1'b1);
        check("glitch_busy", busy16, 1'b0);
        check("glitch_rises", rise16 - r0, 0);
        check("glitch_ferr", fecnt16 - f0, 0);
        check("glitch_data", data16, d0);
        check("glitch_done", done16, dn0);

        // Reset during data bit 4 of 0xFF.
        drive16(1'b0, 16);
        drive16(1'b1, 16 * 4 + 8);
        rst_n = 1'b0;
        wait_cyc(3);
        check("midrst_data", data16, 8'h00);
        check("midrst_done", done16, 1'b0);
        check("midrst_ferr", ferr16, 1'b0);
        check("midrst_busy", busy16, 1'b0);
        rst_n = 1'b1;
        drive16(1'b1, 8 + 48 + 16 + 20);
        r0 = rise16;
        send16(8'h30, 0);
        wait_cyc(10);
        check("midrst_rises", rise16 - r0, 1);
        check("midrst_next", data16, 8'h30);

        // Line already low when reset releases must not start a frame.
        drive16(1'b0, 4);
        rst_n = 1'b0;
        wait_cyc(3);
        rst_n = 1'b1;
        b0 = busycyc16;
        wait_cyc(100);
        check("lowrst_idle", busycyc16 - b0, 0);
        drive16(1'b1, 20);
        r0 = rise16;
        send16(8'h5A, 0);
        wait_cyc(10);
        check("lowrst_rises", rise16 - r0, 1);
        check("lowrst_data", data16, 8'h5A);

        // Random frames against a queue of expected accepted bytes.
        base = got16.size(); f0 = fecnt16; nbad = 0;
        for (int i = 0; i < 24; i++) begin
            b = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                nbad++;
                send16(b, $urandom_range(10, 50));
            end else begin
                exp_q.push_back(b);
                send16(b, 0);
            end
            wait_cyc($urandom_range(0, 40));
        end
        wait_cyc(10);
        check("rand_count", got16.size() - base, exp_q.size());
        check("rand_ferr", fecnt16 - f0, nbad);
        for (int i = 0; i < exp_q.size(); i++) begin
            check($sformatf("rand_byte%0d", i),
                  (base + i < got16.size()) ? {24'h0, got16[base + i]} : 32'hDEAD, exp_q[i]);
        end

        // Odd bit period with +/-3% sender skew.
        s17 = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        sk17 = '{175.1, 164.9, 164.9, 175.1};
        base = got17.size();
        for (int i = 0; i < 4; i++) send17(s17[i], sk17[i]);
        wait_cyc(20);
        check("skew_count", got17.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("skew_byte%0d", i),
                  (base + i < got17.size()) ? {24'h0, got17[base + i]} : 32'hDEAD, s17[i]);
        end
        check("skew_ferr", fecnt17, 0);

        check("ferr_one_cycle16", fecyc16, fecnt16);
        check("ferr_one_cycle17", fecyc17, fecnt17);
        check("data_only_on_rise", datachg16, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
